// File: rtl/apb_periph_bridge_pkg.sv
// Shared types and constants for the multi-channel APB-to-peripheral bridge.
package apb_periph_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    DONE,
    ERR
  } state_t;

  localparam int          CH_SEL_BITS = 3;
  localparam logic [31:0] ERR_RDATA   = 32'h0;

endpackage

// File: rtl/apb_bridge_timeout.sv
// Cycle watchdog for the bridge: cleared at request start, counts while enabled,
// flags expiry on the TIMEOUT_CYCLES-th enabled cycle. TIMEOUT_CYCLES=0 never expires.
module apb_bridge_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = clr ^ en;
      assign expire        = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
      logic [CW-1:0] count_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_reg <= '0;
        end else if (clr) begin
          count_reg <= '0;
        end else if (en) begin
          count_reg <= count_reg + 1'b1;
        end
      end

      // Expiry fires during the last allowed cycle so the FSM leaves on that edge.
      assign expire = en && (count_reg == LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_periph_bridge_mc.sv
// Registered APB4 slave fanning out to NUM_CHANNELS req/gnt/r_valid peripheral targets,
// with channel decode from PADDR, response tag checking and a response watchdog.
module apb_periph_bridge_mc
  import apb_periph_bridge_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_CHANNELS   = 2,
  parameter int CH_LSB         = 8,
  parameter int ID_WIDTH       = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0]        PADDR,
  input  logic [31:0]                      PWDATA,
  input  logic [3:0]                       PSTRB,
  input  logic                             PWRITE,
  input  logic                             PSEL,
  input  logic                             PENABLE,
  output logic [31:0]                      PRDATA,
  output logic                             PREADY,
  output logic                             PSLVERR,
  output logic [NUM_CHANNELS-1:0]          per_req_o,
  output logic [CH_LSB-1:0]                per_add_o,
  output logic                             per_wen_o,
  output logic [31:0]                      per_wdata_o,
  output logic [3:0]                       per_be_o,
  output logic [ID_WIDTH-1:0]              per_id_o,
  input  logic [NUM_CHANNELS-1:0]          per_gnt_i,
  input  logic [NUM_CHANNELS-1:0]          per_rvalid_i,
  input  logic [32*NUM_CHANNELS-1:0]       per_rdata_i,
  input  logic [ID_WIDTH*NUM_CHANNELS-1:0] per_rid_i
);

  localparam logic [CH_SEL_BITS:0] NUM_CH_L = (CH_SEL_BITS + 1)'(NUM_CHANNELS);

  state_t                  state_reg;
  logic [CH_SEL_BITS-1:0]  ch_reg;
  logic [ID_WIDTH-1:0]     tag_reg;

  logic [CH_SEL_BITS-1:0]  paddr_ch;
  logic                    ch_valid;
  logic                    setup;
  logic                    tmo_en;
  logic                    tmo_expire;
  logic [NUM_CHANNELS-1:0] new_hit;
  logic [NUM_CHANNELS-1:0] cur_hit;
  logic                    sel_gnt;
  logic                    sel_rvalid;
  logic [31:0]             sel_rdata;
  logic [ID_WIDTH-1:0]     sel_rid;
  logic                    unused_paddr;

  assign paddr_ch     = PADDR[CH_LSB +: CH_SEL_BITS];
  assign ch_valid     = {1'b0, paddr_ch} < NUM_CH_L;
  assign setup        = (state_reg == IDLE) && PSEL && !PENABLE;
  assign tmo_en       = (state_reg == REQ) || (state_reg == RESP);
  assign unused_paddr = ^PADDR;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      assign new_hit[gi] = (paddr_ch == CH_SEL_BITS'(gi));
      assign cur_hit[gi] = (ch_reg == CH_SEL_BITS'(gi));
    end
  endgenerate

  // Only the latched channel is listened to; activity on other targets is ignored.
  assign sel_gnt    = |(per_gnt_i & cur_hit);
  assign sel_rvalid = |(per_rvalid_i & cur_hit);

  always_comb begin
    sel_rdata = '0;
    sel_rid   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (cur_hit[i]) begin
        sel_rdata = per_rdata_i[i*32 +: 32];
        sel_rid   = per_rid_i[i*ID_WIDTH +: ID_WIDTH];
      end
    end
  end

  apb_bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .clr   (setup),
    .en    (tmo_en),
    .expire(tmo_expire)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg   <= IDLE;
      ch_reg      <= '0;
      tag_reg     <= '0;
      PRDATA      <= '0;
      PREADY      <= 1'b0;
      PSLVERR     <= 1'b0;
      per_req_o   <= '0;
      per_add_o   <= '0;
      per_wen_o   <= 1'b0;
      per_wdata_o <= '0;
      per_be_o    <= '0;
      per_id_o    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (setup) begin
            if (ch_valid) begin
              ch_reg      <= paddr_ch;
              per_req_o   <= new_hit;
              per_add_o   <= PADDR[CH_LSB-1:0];
              per_wen_o   <= !PWRITE;
              per_wdata_o <= PWDATA;
              per_be_o    <= PWRITE ? PSTRB : 4'hF;
              per_id_o    <= tag_reg;
              state_reg   <= REQ;
            end else begin
              PREADY    <= 1'b1;
              PSLVERR   <= 1'b1;
              PRDATA    <= ERR_RDATA;
              state_reg <= ERR;
            end
          end
        end
        REQ, RESP: begin
          // Timeout wins over a same-cycle gnt/r_valid; the tag still advances so a
          // late response from the abandoned target mismatches.
          if (tmo_expire) begin
            per_req_o <= '0;
            tag_reg   <= tag_reg + 1'b1;
            PREADY    <= 1'b1;
            PSLVERR   <= 1'b1;
            PRDATA    <= ERR_RDATA;
            state_reg <= ERR;
          end else if (state_reg == REQ) begin
            if (sel_gnt) begin
              per_req_o <= '0;
              state_reg <= RESP;
            end
          end else if (sel_rvalid) begin
            PRDATA    <= per_wen_o ? sel_rdata : '0;
            PSLVERR   <= (sel_rid != tag_reg);
            PREADY    <= 1'b1;
            tag_reg   <= tag_reg + 1'b1;
            state_reg <= DONE;
          end
        end
        DONE, ERR: begin
          PREADY    <= 1'b0;
          PSLVERR   <= 1'b0;
          PRDATA    <= '0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_periph_bridge_mc.sv
// Randomised scoreboard bench for apb_periph_bridge_mc: APB master + target model issue
// transfers and push expected responses; a negedge monitor pops and compares on PREADY.
module tb_apb_periph_bridge_mc;

  localparam int AW  = 12;
  localparam int NCH = 2;
  localparam int CHL = 8;
  localparam int IDW = 4;
  localparam int TO  = 8;
  localparam int RW  = IDW * NCH;

  logic              HCLK;
  logic              HRESETn;
  logic [AW-1:0]     PADDR;
  logic [31:0]       PWDATA;
  logic [3:0]        PSTRB;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [NCH-1:0]    per_req_o;
  logic [CHL-1:0]    per_add_o;
  logic              per_wen_o;
  logic [31:0]       per_wdata_o;
  logic [3:0]        per_be_o;
  logic [IDW-1:0]    per_id_o;
  logic [NCH-1:0]    per_gnt_i;
  logic [NCH-1:0]    per_rvalid_i;
  logic [32*NCH-1:0] per_rdata_i;
  logic [RW-1:0]     per_rid_i;

  apb_periph_bridge_mc #(
    .APB_ADDR_WIDTH(AW),
    .NUM_CHANNELS  (NCH),
    .CH_LSB        (CHL),
    .ID_WIDTH      (IDW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PSTRB       (PSTRB),
    .PWRITE      (PWRITE),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .per_req_o   (per_req_o),
    .per_add_o   (per_add_o),
    .per_wen_o   (per_wen_o),
    .per_wdata_o (per_wdata_o),
    .per_be_o    (per_be_o),
    .per_id_o    (per_id_o),
    .per_gnt_i   (per_gnt_i),
    .per_rvalid_i(per_rvalid_i),
    .per_rdata_i (per_rdata_i),
    .per_rid_i   (per_rid_i)
  );

  typedef struct {
    logic [31:0] prdata;
    logic        pslverr;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   model_tag = 0;
  int   txn_n = 0;
  logic prev_ready = 1'b0;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_apb"}, 64'({PRDATA, PREADY, PSLVERR}), 64'(0));
    check({tag, "_per"}, 64'({per_req_o, per_add_o, per_wen_o, per_be_o, per_id_o, per_wdata_o}), 64'(0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  // One APB transfer plus the target's behaviour for it (g grant wait, r response wait).
  task automatic apb_xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wd,
                          input logic [3:0] strb, input logic [31:0] rdv, input int g, input int r,
                          input bit do_gnt, input bit do_rv, input int rid_ov, input bit noise,
                          input bit drop_psel, input bit rst_resp);
    int             ch;
    bit             is_err;
    bit             is_to;
    bit             done;
    int             exp_nreq;
    int             n_req;
    int             n_bad;
    logic [IDW-1:0] tag_now;
    logic [IDW-1:0] rid;
    logic [NCH-1:0] onehot;
    exp_t           e;

    ch      = int'(addr >> CHL) & 7;
    is_err  = (ch >= NCH);
    tag_now = model_tag[IDW-1:0];
    rid     = (rid_ov < 0) ? tag_now : rid_ov[IDW-1:0];
    is_to   = !is_err && (!do_gnt || !do_rv || (g + r + 2 >= TO));
    onehot  = '0;
    if (!is_err) onehot[ch] = 1'b1;
    exp_nreq = is_err ? 0 : ((!do_gnt || g + 1 > TO) ? TO : g + 1);

    if (is_err) begin
      e.prdata = 32'h0; e.pslverr = 1'b1; e.lat = 1;
    end else if (is_to) begin
      e.prdata = 32'h0; e.pslverr = 1'b1; e.lat = TO + 1;
      model_tag = (model_tag + 1) % 16;
    end else begin
      e.prdata = wr ? 32'h0 : rdv; e.pslverr = (rid != tag_now); e.lat = g + r + 3;
      model_tag = (model_tag + 1) % 16;
    end

    PADDR = addr; PWRITE = wr; PWDATA = wd; PSTRB = strb;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge HCLK);
    #1;
    PENABLE = 1'b1;
    if (!rst_resp) begin
      e.t0 = cyc;
      sb_q.push_back(e);
    end

    n_req = 0; n_bad = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (PREADY) begin
        done = 1'b1;
      end else begin
        if (per_req_o != '0) begin
          n_req++;
          if (per_req_o !== onehot || per_add_o !== addr[CHL-1:0] || per_wen_o !== !wr ||
              per_be_o !== (wr ? strb : 4'hF) || per_id_o !== tag_now || (wr && per_wdata_o !== wd))
            n_bad++;
        end
        if (rst_resp && k == g + 1) begin
          #2 HRESETn = 1'b0;
          #1;
          check_all_zero("reset_mid_resp");
          PSEL = 1'b0; PENABLE = 1'b0;
          repeat (2) @(posedge HCLK);
          #1 HRESETn = 1'b1;
          model_tag = 0;
          done = 1'b1;
        end else begin
          per_rdata_i = {$urandom, $urandom};
          per_rid_i   = RW'($urandom);
          if (!is_err) begin
            if (noise && k < g) per_gnt_i[ch ^ 1] = 1'b1;
            if (noise && k > g) per_rvalid_i[ch ^ 1] = 1'b1;
            if (do_gnt && k == g) begin
              per_gnt_i[ch] = 1'b1;
              if (noise) begin
                per_rvalid_i[ch] = 1'b1;
                per_rid_i[ch*IDW +: IDW] = rid;
              end
            end
            if (do_gnt && do_rv && k == g + 1 + r) begin
              per_rvalid_i[ch] = 1'b1;
              per_rdata_i[ch*32 +: 32] = rdv;
              per_rid_i[ch*IDW +: IDW] = rid;
            end
          end
          if (drop_psel && k == 1) begin
            PSEL = 1'b0; PENABLE = 1'b0;
          end
          @(posedge HCLK);
          #1;
          per_gnt_i = '0; per_rvalid_i = '0;
        end
      end
    end

    if (!rst_resp) begin
      check("handshake_budget", 64'(done), 64'(1));
      check("req_cycles", 64'(n_req), 64'(exp_nreq));
      check("req_payload", 64'(n_bad), 64'(0));
      @(posedge HCLK);
      #1;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic stray_rvalid(input int ch, input int rid);
    per_rvalid_i[ch] = 1'b1;
    per_rid_i[ch*IDW +: IDW] = rid[IDW-1:0];
    per_gnt_i[ch] = 1'b1;
    idle(1);
    per_rvalid_i = '0; per_gnt_i = '0;
    idle(2);
    check("stray_rvalid_idle", 64'({PREADY, per_req_o}), 64'(0));
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (HRESETn && PREADY) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pready", 64'(1), 64'(0));
        end else begin
          e = sb_q.pop_front();
          txn_n++;
          check("prdata", 64'(PRDATA), 64'(e.prdata));
          check("pslverr", 64'(PSLVERR), 64'(e.pslverr));
          check("latency", 64'(cyc - e.t0 + 1), 64'(e.lat));
          check("pready_single", 64'(prev_ready), 64'(0));
          $display("txn %0d: PRDATA=%08h PSLVERR=%0b latency=%0d", txn_n, PRDATA, PSLVERR, cyc - e.t0 + 1);
        end
      end
      prev_ready = HRESETn && PREADY;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end

  initial begin
    int            old_tag;
    int            chs;
    int            g;
    int            r;
    int            ridv;
    logic [AW-1:0] a;

    HRESETn = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    per_gnt_i = '0; per_rvalid_i = '0; per_rdata_i = '0; per_rid_i = '0;
    idle(3);
    check_all_zero("reset_state");
    HRESETn = 1'b1;
    idle(1);

    // zero-wait read ch1, then a write with 3 grant wait states on ch0
    apb_xfer(12'h104, 1'b0, 32'h0, 4'h0, 32'hCAFE_0001, 0, 0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    apb_xfer(12'h010, 1'b1, 32'h5566_7788, 4'b0011, 32'h0BAD_0BAD, 3, 0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    // unmapped channels, and PADDR bit above the select field ignored
    apb_xfer(12'h300, 1'b0, 32'h0, 4'h0, 32'h0, 0, 0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    apb_xfer(12'h7FC, 1'b1, 32'h1, 4'hF, 32'h0, 0, 0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    apb_xfer(12'h8FF, 1'b0, 32'h0, 4'h0, 32'h0000_08FF, 1, 1, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);

    // timeout, stray response while idle, then the late response on the next read
    old_tag = model_tag;
    apb_xfer(12'h020, 1'b0, 32'h0, 4'h0, 32'h1234_5678, 0, 0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    stray_rvalid(0, old_tag);
    apb_xfer(12'h024, 1'b0, 32'h0, 4'h0, 32'hBEEF_0004, 0, 0, 1'b1, 1'b1, old_tag, 1'b0, 1'b0, 1'b0);

    // reflected tag off by one, then 16 reads to wrap the tag
    apb_xfer(12'h108, 1'b0, 32'h0, 4'h0, 32'hA5A5_0108, 0, 1, 1'b1, 1'b1, (model_tag + 1) % 16, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 16; n++) begin
      a = AW'($urandom_range(0, 255));
      a[CHL] = 1'($urandom_range(0, 1));
      apb_xfer(a, 1'b0, 32'h0, 4'h0, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               1'b1, 1'b1, -1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // reset while waiting for the response, then a fresh read must use tag 0
    apb_xfer(12'h130, 1'b0, 32'h0, 4'h0, 32'h0, 1, 2, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b1);
    idle(1);
    apb_xfer(12'h134, 1'b0, 32'h0, 4'h0, 32'h0F0F_1340, 0, 0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);

    // master drops PSEL/PENABLE mid-transfer; bridge still completes
    apb_xfer(12'h0A0, 1'b1, 32'hDEAD_00A0, 4'b1100, 32'h0, 1, 1, 1'b1, 1'b1, -1, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 150; n++) begin
      chs = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 7)) : int'($urandom_range(0, 1));
      a = AW'($urandom);
      a[CHL +: 3] = 3'(chs);
      g = int'($urandom_range(0, 2));
      r = int'($urandom_range(0, 2));
      ridv = ($urandom_range(0, 7) == 0) ? (model_tag + 1 + int'($urandom_range(0, 14))) % 16 : -1;
      apb_xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom, g, r,
               1'b1, 1'b1, ridv, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      idle(int'($urandom_range(0, 2)));
    end

    idle(4);
    check("scoreboard_drain", 64'(sb_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
